// File: rtl/freq_dec_pkg.sv
// Shared types and default constants for the frequency decoder.
package freq_dec_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int CNT_W_DEF      = 8;
  localparam int MIN_PERIOD_DEF = 2;
  localparam int TIMEOUT_DEF    = 255;

  typedef logic [CNT_W_DEF-1:0] period_t;

endpackage

// File: rtl/pulse_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pulse train followed by a
// rising-edge detector. The edge output is combinational from the last
// synchronizer stage and the remembered previous synced level.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the input through the synchronizer chain and keep the last synced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/frequency_decoder.sv
// Frequency decoder: measures clk cycles between rising edges of a pulse
// train, reports each accepted period with a one-cycle strobe, flags
// glitches and signal loss, and reports lock on two equal periods.
module frequency_decoder
  import freq_dec_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_input,
  output logic [CNT_W-1:0] data_output,
  output logic             data_valid,
  output logic             locked,
  output logic             timeout,
  output logic             glitch
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic             edge_w;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             locked_q, locked_d;
  logic             dv_q, dv_d;
  logic             to_q, to_d;
  logic             gl_q, gl_d;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(pulse_input),
    .edge_out(edge_w)
  );

  // State, counter, period record and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      locked_q    <= 1'b0;
      dv_q        <= 1'b0;
      to_q        <= 1'b0;
      gl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      locked_q    <= locked_d;
      dv_q        <= dv_d;
      to_q        <= to_d;
      gl_q        <= gl_d;
    end
  end

  // Next-state logic: an edge takes priority over the timeout check
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    locked_d    = locked_q;
    dv_d        = 1'b0;
    to_d        = 1'b0;
    gl_d        = 1'b0;
    if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      locked_d    = 1'b0;
      have_prev_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_w) begin
            state_d     = MEASURE;
            cnt_d       = ONE_C;
            have_prev_d = 1'b0;
          end
        end
        MEASURE: begin
          if (edge_w) begin
            if (cnt_q >= MIN_C) begin
              data_d      = cnt_q;
              dv_d        = 1'b1;
              cnt_d       = ONE_C;
              locked_d    = have_prev_q && (cnt_q == prev_q);
              prev_d      = cnt_q;
              have_prev_d = 1'b1;
            end else begin
              gl_d  = 1'b1;
              cnt_d = cnt_q + ONE_C;
            end
          end else if (cnt_q == TO_C) begin
            state_d     = IDLE;
            to_d        = 1'b1;
            locked_d    = 1'b0;
            cnt_d       = '0;
            have_prev_d = 1'b0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_output = data_q;
  assign data_valid  = dv_q;
  assign locked      = locked_q;
  assign timeout     = to_q;
  assign glitch      = gl_q;

endmodule

// File: tb/tb_frequency_decoder.sv
// Bench for frequency_decoder: a table of pulse intervals with hand-derived
// results, hand-written corner sequences, and a randomized run compared every
// cycle against a timestamp-based reference model. A second instance with a
// larger minimum period exercises glitch rejection.
module tb_frequency_decoder;

  localparam int S  = 2;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst, enable, pulse_input;
  logic [7:0] d2, d3;
  logic       v2, l2, t2, g2, v3, l3, t3, g3;

  always #5 clk = ~clk;

  frequency_decoder #(.CNT_W(8), .SYNC_STAGES(S), .MIN_PERIOD(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pulse_input(pulse_input),
    .data_output(d2), .data_valid(v2), .locked(l2), .timeout(t2), .glitch(g2));

  frequency_decoder #(.CNT_W(8), .SYNC_STAGES(S), .MIN_PERIOD(3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .pulse_input(pulse_input),
    .data_output(d3), .data_valid(v3), .locked(l3), .timeout(t3), .glitch(g3));

  int checks = 0;
  int errors = 0;

  // Reference model state: time of last accepted edge, last period, flags.
  typedef struct {
    bit         armed;
    int         t0;
    bit         hp;
    int         prev;
    logic [7:0] data;
    bit         dv, lk, to, gl;
  } mdl_t;

  mdl_t       m2, m3;
  bit         smp[0:S];
  int         tk = 0;
  logic [11:0] log2[0:1023];
  logic [11:0] log3[0:1023];

  function automatic mdl_t mstep(mdl_t m, bit e, bit en, int k, int minp);
    int p;
    m.dv = 0; m.to = 0; m.gl = 0;
    p = k - m.t0;
    if (!en) begin
      m.armed = 0; m.hp = 0; m.lk = 0;
    end else if (e) begin
      if (!m.armed) begin
        m.armed = 1; m.t0 = k; m.hp = 0;
      end else if (p >= minp) begin
        m.dv = 1; m.data = 8'(p);
        m.lk = m.hp && (p == m.prev);
        m.prev = p; m.hp = 1; m.t0 = k;
      end else begin
        m.gl = 1;
      end
    end else if (m.armed && p == TO) begin
      m.armed = 0; m.to = 1; m.lk = 0; m.hp = 0;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [11:0] L2(int i);
    return log2[i % 1024];
  endfunction

  function automatic logic [11:0] L3(int i);
    return log3[i % 1024];
  endfunction

  task automatic model_reset();
    m2 = '{default: 0};
    m3 = '{default: 0};
    for (int i = 0; i <= S; i++) smp[i] = 0;
  endtask

  // One clock: drive inputs, advance model at the edge, compare at the falling edge.
  task automatic tick(input bit p, input bit en);
    bit e;
    pulse_input = p;
    enable      = en;
    @(posedge clk);
    e  = smp[S-1] & ~smp[S];
    m2 = mstep(m2, e, en, tk, 2);
    m3 = mstep(m3, e, en, tk, 3);
    for (int i = S; i > 0; i--) smp[i] = smp[i-1];
    smp[0] = p;
    @(negedge clk);
    log2[tk % 1024] = {d2, v2, l2, t2, g2};
    log3[tk % 1024] = {d3, v3, l3, t3, g3};
    chk("model_min2", {d2, v2, l2, t2, g2}, {m2.data, m2.dv, m2.lk, m2.to, m2.gl});
    chk("model_min3", {d3, v3, l3, t3, g3}, {m3.data, m3.dv, m3.lk, m3.to, m3.gl});
    tk++;
  endtask

  // One rising edge followed by len-1 further cycles; high for hi cycles.
  task automatic pulse_gap(input int len, input int hi, input bit en, output int rise);
    rise = tk;
    for (int i = 0; i < len; i++) tick(i < hi, en);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_min2", {d2, v2, l2, t2, g2}, 0);
    chk("rst_async_min3", {d3, v3, l3, t3, g3}, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int len;
    bit dv;
    int data;
    bit lk;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] v;
    int r, ra, rb, rc, r3, rd, rx, re1, re2, rr1, rr2, acc;
    int len, hi;
    bit en;

    tbl = '{'{10, 0, 0, 0}, '{10, 1, 10, 0}, '{12, 1, 10, 1}, '{12, 1, 12, 0},
            '{10, 1, 12, 1}, '{5, 1, 10, 0}, '{5, 1, 5, 0}, '{20, 1, 5, 1}};

    rst = 1'b1; enable = 1'b0; pulse_input = 1'b0;
    model_reset();
    #1;
    chk("reset_min2", {d2, v2, l2, t2, g2}, 0);
    chk("reset_min3", {d3, v3, l3, t3, g3}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Steady trains and period changes
    for (int i = 0; i < 8; i++) begin
      pulse_gap(tbl[i].len, 1, 1'b1, r);
      v = L2(r + 2);
      chk($sformatf("tbl%0d_dv", i), v[3], tbl[i].dv);
      chk($sformatf("tbl%0d_data", i), v[11:4], tbl[i].data);
      chk($sformatf("tbl%0d_lock", i), v[2], tbl[i].lk);
      chk($sformatf("tbl%0d_timeout", i), v[1], 0);
      if (i == 1) begin
        v = L2(r + 1);
        chk("latency_early_dv", v[3], 0);
      end
    end

    // Glitch: extra edge two cycles after an accepted edge
    pulse_gap(2, 1, 1'b1, ra);
    pulse_gap(8, 1, 1'b1, rb);
    pulse_gap(10, 1, 1'b1, rc);
    v = L3(rb + 2);
    chk("glitch_strobe", v[0], 1);
    chk("glitch_no_dv", v[3], 0);
    chk("glitch_data_held", v[11:4], 20);
    v = L3(rb + 3);
    chk("glitch_one_cycle", v[0], 0);
    v = L2(rb + 2);
    chk("min2_accepts_2", {v[11:4], v[3]}, {8'd2, 1'b1});
    v = L3(rc + 2);
    chk("after_glitch_data", {v[11:4], v[3]}, {8'd10, 1'b1});
    v = L2(rc + 2);
    chk("min2_after_data", v[11:4], 8);

    // Signal loss after lock, then re-arm and an edge exactly at the limit
    pulse_gap(10, 1, 1'b1, r);
    pulse_gap(10, 1, 1'b1, r);
    pulse_gap(300, 1, 1'b1, r3);
    v = L2(r3 + 2);
    chk("pre_loss_lock", v[2], 1);
    v = L2(r3 + 256);
    chk("loss_not_early", v[1], 0);
    v = L2(r3 + 257);
    chk("loss_timeout", {v[11:4], v[2], v[1]}, {8'd10, 1'b0, 1'b1});
    v = L2(r3 + 258);
    chk("loss_one_cycle", v[1], 0);
    pulse_gap(255, 1, 1'b1, ra);
    v = L2(ra + 2);
    chk("rearm_silent", v[3], 0);
    pulse_gap(10, 1, 1'b1, rb);
    v = L2(rb + 2);
    chk("edge_at_limit", {v[11:4], v[3], v[1]}, {8'd255, 1'b1, 1'b0});
    v = L2(rb + 1);
    chk("edge_at_limit_no_to", v[1], 0);

    // Enable drop during a 10-cycle train
    pulse_gap(10, 3, 1'b1, rd);
    pulse_gap(10, 3, 1'b1, rd);
    v = L2(rd + 2);
    chk("pre_disable_lock", v[2], 1);
    pulse_gap(10, 3, 1'b0, rx);
    pulse_gap(10, 3, 1'b0, r);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      v = L2(rx + i);
      acc = acc | int'(v[3]) | int'(v[1]) | int'(v[0]) | int'(v[2]);
    end
    chk("disabled_quiet", acc, 0);
    pulse_gap(10, 3, 1'b1, re1);
    pulse_gap(10, 3, 1'b1, re2);
    v = L2(re1 + 2);
    chk("reenable_silent", v[3], 0);
    v = L2(re2 + 2);
    chk("reenable_period", {v[11:4], v[3], v[2]}, {8'd10, 1'b1, 1'b0});

    // Reset while locked and mid-measurement
    pulse_gap(10, 1, 1'b1, r);
    tick(0, 1); tick(0, 1); tick(0, 1);
    mid_reset();
    pulse_gap(10, 1, 1'b1, rr1);
    pulse_gap(10, 1, 1'b1, rr2);
    v = L2(rr1 + 2);
    chk("post_rst_first_silent", v[3], 0);
    v = L2(rr2 + 2);
    chk("post_rst_second", {v[11:4], v[3]}, {8'd10, 1'b1});

    // Randomized pulse trains against the reference model
    for (int i = 0; i < 120; i++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 260)) : int'($urandom_range(2, 30));
      hi  = int'($urandom_range(1, len - 1));
      en  = ($urandom_range(0, 11) != 0);
      pulse_gap(len, hi, en, r);
      if (i == 60) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
